// File: rtl/reg_snapshot_ctrl_if.sv
// Bus between the checkpoint controller and the register file / decode / resolve logic.
// The controller takes the master modport; the register-file side takes the slave.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface reg_snapshot_ctrl_if #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                             cp_req;
  logic [31:0][DATA_WIDTH-1:0]      regs_in;
  logic                             wb_uses_rw;
  logic [4:0]                       wb_rw_addr;
  logic [DATA_WIDTH-1:0]            wb_rw_data;
  logic                             resolve_valid;
  logic                             resolve_mispredict;
  logic                             rf_done;
  logic [31:0][DATA_WIDTH-1:0]      regs_snapshot;
  logic                             recover_snapshot;
  logic                             recovery_done_ack;
  logic                             busy;
  logic                             full;
  logic [CntW-1:0]                  count;
  logic                             err;

  modport master (
    input  cp_req, regs_in, wb_uses_rw, wb_rw_addr, wb_rw_data,
    input  resolve_valid, resolve_mispredict, rf_done,
    output regs_snapshot, recover_snapshot, recovery_done_ack, busy, full, count, err
  );

  modport slave (
    output cp_req, regs_in, wb_uses_rw, wb_rw_addr, wb_rw_data,
    output resolve_valid, resolve_mispredict, rf_done,
    input  regs_snapshot, recover_snapshot, recovery_done_ack, busy, full, count, err
  );
endinterface

// File: rtl/reg_snapshot_ctrl.sv
// Register-file checkpoint controller: captures a snapshot per predicted branch into an
// in-order queue, retires on correct resolution, restores the oldest on a mispredict.
// Optional SNAPSHOT_TRACE_EN: simulation trace of captures and restored registers.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_snapshot_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned REG_COUNT  = 32
) (
  input logic                 clk,
  input logic                 rst,
  reg_snapshot_ctrl_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [REG_COUNT-1:0][DATA_WIDTH-1:0] snap_t;
  typedef enum logic [1:0] {StIdle, StRecover, StWaitDone, StAck} state_e;

  state_e          state_q;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  snap_t           mem_q [DEPTH];
  snap_t           snapshot_q;
  snap_t           cap_snap;
  logic            recover_q, ack_q, busy_q, err_q;

  logic idle, full, has_entry, mis_start, retire, capture, cp_overflow, resolve_empty;

  // Decode this cycle's queue operations; nothing is accepted outside IDLE.
  always_comb begin
    idle          = (state_q == StIdle);
    full          = (count_q == CntW'(DEPTH));
    has_entry     = (count_q != '0);
    mis_start     = idle && bus.resolve_valid && bus.resolve_mispredict && has_entry;
    retire        = idle && bus.resolve_valid && !bus.resolve_mispredict && has_entry;
    // A capture alongside a mispredict is wrong-path and silently dropped.
    capture       = idle && bus.cp_req && !mis_start && (!full || retire);
    cp_overflow   = idle && bus.cp_req && !mis_start && full && !retire;
    resolve_empty = idle && bus.resolve_valid && !has_entry;
  end

  // Snapshot to store: same-cycle write-back wins, r0 is hardwired zero.
  always_comb begin
    cap_snap = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      if (bus.wb_uses_rw && (bus.wb_rw_addr == 5'(i))) cap_snap[i] = bus.wb_rw_data;
      else                                               cap_snap[i] = bus.regs_in[i];
    end
  end

  // Checkpoint storage; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (!rst && capture) mem_q[tail_q] <= cap_snap;
  end

  // Queue pointers and recovery FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      snapshot_q <= '0;
      recover_q  <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (cp_overflow || resolve_empty) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (mis_start) begin
            snapshot_q <= mem_q[head_q];
            recover_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StRecover;
          end else begin
            if (capture) tail_q <= tail_q + 1'b1;
            if (retire)  head_q <= head_q + 1'b1;
            if (capture && !retire)      count_q <= count_q + CntW'(1);
            else if (retire && !capture) count_q <= count_q - CntW'(1);
          end
        end
        StRecover: begin
          recover_q <= 1'b0;
          state_q   <= StWaitDone;
        end
        StWaitDone: begin
          if (bus.rf_done) begin
            ack_q   <= 1'b1;
            state_q <= StAck;
          end
        end
        StAck: begin
          // Restored state invalidates every younger checkpoint.
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.regs_snapshot     = snapshot_q;
  assign bus.recover_snapshot  = recover_q;
  assign bus.recovery_done_ack = ack_q;
  assign bus.busy              = busy_q;
  assign bus.full              = full;
  assign bus.count             = count_q;
  assign bus.err               = err_q;

`ifdef SNAPSHOT_TRACE_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter for trace timestamps.
  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_q + 32'd1;
  end

  // Trace captures and restored register contents.
  always_ff @(posedge clk) begin
    if (!rst && capture) $display("snapshot capture: cycle %0d slot %0d", cycle_q, tail_q);
    if (!rst && state_q == StRecover) begin
      $display("snapshot restore: cycle %0d", cycle_q);
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        $display("  r%0d = %h", i, snapshot_q[i]);
      end
    end
  end
`endif

endmodule

// File: doc/reg_snapshot_ctrl.md
Name: reg_snapshot_ctrl

Overview:
- Checkpoint controller on the initiator side of the register-file snapshot-recovery protocol.
- On each predicted branch from decode, it captures a full copy of the architectural register file into an in-order checkpoint queue.
- When a branch resolves correctly, the oldest checkpoint is retired.
- When a branch resolves as a misprediction, the controller drives the oldest snapshot into the register file, pulses the recovery request, waits for the register file's done, acknowledges, and flushes all younger checkpoints.

Parameters:
- DEPTH, 4, number of outstanding checkpoints (power of two, ≥2).
- DATA_WIDTH, `DATA_WIDTH, register width.
- REG_COUNT, 32, registers per snapshot (fixed at 32).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cp_req  in  1  capture a checkpoint this cycle (predicted branch in decode).
- regs_in  in  DATA_WIDTH x32  live register contents from the register file.
- wb_uses_rw  in  1  write-back write enable, same-cycle.
- wb_rw_addr  in  5  write-back destination.
- wb_rw_data  in  DATA_WIDTH  write-back data.
- resolve_valid  in  1  oldest outstanding branch resolved.
- resolve_mispredict  in  1  qualifies resolve_valid: 1 = mispredicted.
- rf_done  in  1  register-file done flag.
- regs_snapshot  out  DATA_WIDTH x32  snapshot to restore.
- recover_snapshot  out  1  restore request pulse.
- recovery_done_ack  out  1  recovery complete pulse.
- busy  out  1  recovery sequence in progress; decode/fetch must stall.
- full  out  1  queue holds DEPTH checkpoints.
- count  out  $clog2(DEPTH)+1  occupied entries.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is synchronous and active-high.
  - Reset forces: state=IDLE, head=tail=count=0, recover_snapshot=0, recovery_done_ack=0, busy=0, full=0, err=0, regs_snapshot=0.
  - Reset mid-recovery aborts the sequence immediately; no ack is issued.
- Queue:
  - Circular buffer of DEPTH snapshots with head (oldest) and tail pointers. Pointers wrap modulo DEPTH.
  - full = (count==DEPTH).
- Capture (IDLE, cp_req=1, not full):
  - Entry[tail][i] <= (wb_uses_rw && wb_rw_addr==i && i!=0) ? wb_rw_data : regs_in[i]. This bypasses the same-cycle write-back.
  - Register 0 is always stored as 0.
  - tail++, count++.
- Retire (IDLE, resolve_valid=1, resolve_mispredict=0, count>0): head++, count--.
- Same-cycle capture + retire: both occur and count is unchanged. When count was DEPTH, the capture is permitted because the retire frees a slot in the same cycle.
- cp_req while full with no same-cycle retire: request dropped, err<=1.
- resolve_valid while count==0: ignored, err<=1. This also applies to a mispredict with an empty queue: no recovery starts.
- Recovery FSM (states IDLE, RECOVER, WAIT_DONE, ACK):
  - IDLE → RECOVER on resolve_valid && resolve_mispredict && count>0. On this edge regs_snapshot <= entry[head]. A same-cycle cp_req is dropped without error (wrong path).
  - RECOVER (1 cycle): recover_snapshot=1, busy=1 → WAIT_DONE.
  - WAIT_DONE: busy=1. Stays until rf_done=1, then → ACK. rf_done is sampled only in this state.
  - ACK (1 cycle): recovery_done_ack=1, busy=1. On exit head=tail=count=0 → IDLE.
  - Latency: mispredict resolved at cycle T gives recover_snapshot at T+1, rf_done seen at T+2 (nominal), ack at T+3, busy low at T+4.
- busy is high in RECOVER, WAIT_DONE and ACK; cp_req and resolve_valid are ignored (no error) while busy.
- regs_snapshot holds its value from RECOVER through ACK, and stays stable afterward until the next recovery.

Optional Feature:
- SNAPSHOT_TRACE_EN defined:
  - In RECOVER, $display a banner plus all 32 restored registers (index and hex value).
  - On every capture, $display the capture cycle count and slot index.
- Undefined: no display statements and no cycle counter; functional behaviour is identical.

Test Plan:
- Reset, then cp_req with regs_in[i]=i*0x11 and wb write r5=0xDEAD same cycle → entry0 holds r5=0xDEAD, r0=0, others i*0x11; count=1.
- Capture 4 (DEPTH=4) → full=1; 5th cp_req alone → count stays 4, err=1. Retire+cp_req same cycle when full → count=4, no err.
- Checkpoint A (r1=0x1), then B (r1=0x2); mispredict at T with rf_done tied to model → recover_snapshot at T+1 with regs_snapshot r1=0x1, ack at T+3, count=0 at T+4.
- Hold rf_done=0 for 10 cycles in WAIT_DONE → busy stays 1, no ack; raise rf_done → ack next cycle.
- Capture/retire 9 times with DEPTH=4 (pointer wrap), then mispredict → snapshot equals most recent unretired capture.
- Mispredict with cp_req same cycle → no new entry, err=0; resolve_valid at count=0 → err=1, no recovery.
